priority_encode_display: RTL and testbench
==========================================

// Module: priority_encode_display
// PURPOSE
//   Demo block for the board switch/LED/7-seg panel. A 3-bit code x is expanded onto 8 LEDs,
//   then fed to an 8-to-3 priority encoder (result B) to check the round trip.
//   Left digit shows x, right digit shows B. ET gates the block; flag picks the LED pattern.
// PARAMETERS
//   SEG_ACTIVE_LOW  0  1 = invert all segment outputs (common-anode boards); 0 = active-high
// PORTS
//   clk           in   1  system clock, all state on rising edge
//   rst           in   1  synchronous reset, active-high
//   x             in   3  input code 0..7
//   ET            in   1  enable, active-high
//   flag          in   1  LED pattern select: 0 = one-hot, 1 = thermometer
//   switch_led    out  8  expanded LED pattern
//   a_to_g_left   out  8  left digit segments {dp,g,f,e,d,c,b,a}
//   a_to_g_right  out  8  right digit segments {dp,g,f,e,d,c,b,a}
//   B             out  3  priority-encoder result
//   Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
//   - All outputs registered. Reset (rst=1 at a clk edge): every output = 0, blank digits.
//     With SEG_ACTIVE_LOW=1, the reset segment value is 8'hFF.
//   - Inputs are sampled on each clk edge. Outputs reflect those samples after that same edge.
//     Latency is 1 cycle. Inputs are not synchronised internally; callers supply synchronous signals.
//   - Pattern P (combinational from the sampled inputs):
//       ET=0            -> P = 8'h00
//       ET=1, flag=0    -> P = 8'b1 << x (one-hot)
//       ET=1, flag=1    -> P = (9'b1 << (x+1)) - 1, bits 0..x set (thermometer)
//   - switch_led <= P.
//   - Priority encoder: B = index of the highest set bit of P; bit 7 has the highest priority.
//     If P = 0, B = 3'd0.
//     For any ET=1 input, B = x in both flag modes.
//   - Internal valid flag GS = |P.
//   - Digit font for 0..7, gfedcba: 3F 06 5B 4F 66 6D 7D 07. dp bit = 0 unless stated otherwise.
//   - a_to_g_left  <= ET ? font(x) : 8'h00.
//   - a_to_g_right <= GS ? font(B) : 8'h00.
//   - If SEG_ACTIVE_LOW=1, both segment outputs are inverted after the font and blank selection.
//   - Simultaneous changes of x, ET and flag within one cycle resolve on a single edge.
//     No intermediate output states.
//   - Reset has priority over any input change on the same edge.
//     Reset mid-operation blanks everything on the next edge.
//     Normal operation resumes on the first edge with rst=0.
// CONFIGURATION
//   PRIENC_DP_EN defined: dp (bit 7) of a_to_g_right = ~GS when ET=0, i.e. the point lights
//     while the block is disabled. The result is still subject to SEG_ACTIVE_LOW inversion.
//     The point is off after reset.
//   PRIENC_DP_EN undefined: dp bits of both digits are always 0 (before inversion).
// TESTING
//   1. rst=1 for 2 cycles, any inputs -> switch_led=00, B=0, a_to_g_left=00, a_to_g_right=00.
//   2. ET=1, flag=0, sweep x=0..7 -> switch_led=01,02,..,80; B=x;
//      a_to_g_left = a_to_g_right = font(x), e.g. x=5 -> 6D; each update 1 cycle after the input change.
//   3. ET=1, flag=1, x=5 -> switch_led=3F, B=5, right digit 6D; x=0 -> switch_led=01, B=0, right digit 3F.
//   4. ET=0, any x/flag -> switch_led=00, B=0, both digits 00.
//      With PRIENC_DP_EN defined -> a_to_g_right=80.
//   5. ET=1, x=7, flag=0; assert rst for 1 cycle -> all outputs 0 on that edge; next edge -> switch_led=80, B=7.
//   6. SEG_ACTIVE_LOW=1, ET=1, flag=0, x=3 -> a_to_g_left = a_to_g_right = B0 (inverse of 4F).

Source files
------------

// File: rtl/priority_encode_display.sv
// rtl/priority_encode_display.sv - 3-bit code to LED pattern, priority-encoded back, shown on two 7-seg digits.
// Optional PRIENC_DP_EN lights the right decimal point while the block is disabled.
module priority_encode_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] x,
  input  logic       ET,
  input  logic       flag,
  output logic [7:0] switch_led,
  output logic [7:0] a_to_g_left,
  output logic [7:0] a_to_g_right,
  output logic [2:0] B
);

  localparam logic [7:0] SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [6:0] font(input logic [2:0] d);
    case (d)
      3'd0:    font = 7'h3F;
      3'd1:    font = 7'h06;
      3'd2:    font = 7'h5B;
      3'd3:    font = 7'h4F;
      3'd4:    font = 7'h66;
      3'd5:    font = 7'h6D;
      3'd6:    font = 7'h7D;
      default: font = 7'h07;
    endcase
  endfunction

  logic [8:0] w_therm9;
  logic [7:0] w_pattern;
  logic [2:0] w_b;
  logic       w_gs;
  logic       w_dp_right;
  logic [7:0] w_left;
  logic [7:0] w_right;

  // Thermometer is built in 9 bits so x=7 does not overflow before the subtract.
  assign w_therm9 = (9'd1 << ({1'b0, x} + 4'd1)) - 9'd1;

  always_comb begin
    w_pattern = 8'h00;
    if (ET) begin
      if (flag) w_pattern = w_therm9[7:0];
      else      w_pattern = 8'h01 << x;
    end
  end

  always_comb begin
    w_b = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_pattern[i]) w_b = 3'(i);
    end
  end

  assign w_gs = |w_pattern;

`ifdef PRIENC_DP_EN
  assign w_dp_right = ~ET & ~w_gs;
`else
  assign w_dp_right = 1'b0;
`endif

  assign w_left  = ET   ? {1'b0, font(x)}   : 8'h00;
  assign w_right = w_gs ? {1'b0, font(w_b)} : {w_dp_right, 7'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      switch_led   <= 8'h00;
      B            <= 3'd0;
      a_to_g_left  <= SEG_MASK;
      a_to_g_right <= SEG_MASK;
    end else begin
      switch_led   <= w_pattern;
      B            <= w_b;
      a_to_g_left  <= w_left ^ SEG_MASK;
      a_to_g_right <= w_right ^ SEG_MASK;
    end
  end

endmodule

// File: tb/tb_priority_encode_display.sv
// tb/tb_priority_encode_display.sv - directed bench for priority_encode_display (both segment polarities).
module tb_priority_encode_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] x;
  logic       ET;
  logic       flag;
  logic [7:0] led_h, left_h, right_h, led_l, left_l, right_l;
  logic [2:0] b_h, b_l;

  int errors = 0;
  int checks = 0;

  logic [7:0] font_t  [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
  logic [7:0] onehot_t[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] therm_t [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

`ifdef PRIENC_DP_EN
  localparam logic [7:0] DIS_RIGHT = 8'h80;
`else
  localparam logic [7:0] DIS_RIGHT = 8'h00;
`endif

  always #5 clk = ~clk;

  priority_encode_display #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .x(x), .ET(ET), .flag(flag),
    .switch_led(led_h), .a_to_g_left(left_h), .a_to_g_right(right_h), .B(b_h)
  );

  priority_encode_display #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .x(x), .ET(ET), .flag(flag),
    .switch_led(led_l), .a_to_g_left(left_l), .a_to_g_right(right_l), .B(b_l)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] xv, input logic e, input logic f);
    @(negedge clk);
    rst = r; x = xv; ET = e; flag = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] led, input logic [2:0] b,
                         input logic [7:0] left, input logic [7:0] right);
    chk({tag, "_led"},   led_h,          led);
    chk({tag, "_B"},     {5'd0, b_h},    {5'd0, b});
    chk({tag, "_left"},  left_h,         left);
    chk({tag, "_right"}, right_h,        right);
    chk({tag, "_Ll"},    left_l,         ~left);
    chk({tag, "_Lr"},    right_l,        ~right);
    chk({tag, "_Lled"},  led_l,          led);
  endtask

  initial begin
    rst = 1'b1; x = 3'd5; ET = 1'b1; flag = 1'b1;
    drive(1'b1, 3'd5, 1'b1, 1'b1);
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    chk_all("reset", 8'h00, 3'd0, 8'h00, 8'h00);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 1'b1, 1'b0);
      chk_all($sformatf("onehot%0d", i), onehot_t[i], 3'(i), font_t[i], font_t[i]);
    end

    // Input change is not visible until the next edge.
    @(negedge clk);
    x = 3'd2;
    #2;
    chk("latency_hold", led_h, 8'h80);
    @(posedge clk);
    #1;
    chk("latency_upd", led_h, 8'h04);

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 1'b1, 1'b1);
      chk_all($sformatf("therm%0d", i), therm_t[i], 3'(i), font_t[i], font_t[i]);
    end
    drive(1'b0, 3'd5, 1'b1, 1'b1);
    chk_all("therm5b", 8'h3F, 3'd5, 8'h6D, 8'h6D);
    drive(1'b0, 3'd0, 1'b1, 1'b1);
    chk_all("therm0b", 8'h01, 3'd0, 8'h3F, 8'h3F);

    drive(1'b0, 3'd7, 1'b0, 1'b0);
    chk_all("dis_a", 8'h00, 3'd0, 8'h00, DIS_RIGHT);
    drive(1'b0, 3'd3, 1'b0, 1'b1);
    chk_all("dis_b", 8'h00, 3'd0, 8'h00, DIS_RIGHT);

    drive(1'b0, 3'd7, 1'b1, 1'b0);
    chk_all("pre_rst", 8'h80, 3'd7, 8'h07, 8'h07);
    drive(1'b1, 3'd7, 1'b1, 1'b0);
    chk_all("mid_rst", 8'h00, 3'd0, 8'h00, 8'h00);
    drive(1'b0, 3'd7, 1'b1, 1'b0);
    chk_all("post_rst", 8'h80, 3'd7, 8'h07, 8'h07);

    // Reset with the block disabled: the decimal point must stay off.
    drive(1'b1, 3'd1, 1'b0, 1'b0);
    chk_all("rst_dis", 8'h00, 3'd0, 8'h00, 8'h00);

    drive(1'b0, 3'd3, 1'b1, 1'b0);
    chk("al_left3",  left_l,  8'hB0);
    chk("al_right3", right_l, 8'hB0);
    chk("al_B3",     {5'd0, b_l}, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
